// File: rtl/mask_arbiter.sv
// mask_arbiter: round-robin arbiter and sequencer sharing one Mask datapath
// between two requesters. The winning operands are registered onto the
// Mask inputs. A tag pipeline follows each operation through the Mask's
// fixed latency so that every result comes back tagged with its requester.
module mask_arbiter #(
  parameter int MASK_LAT = 1,
  parameter int DW       = 15,
  parameter int PW       = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_maskin,
  input  logic [PW-1:0] req0_pos,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_maskin,
  input  logic [PW-1:0] req1_pos,
  output logic [DW-1:0] mask_in,
  output logic [PW-1:0] position,
  input  logic [DW-1:0] mask_out,
  output logic          res_valid,
  output logic          res_id,
  output logic [DW-1:0] res_data,
  output logic          busy
);

  // Round-robin pointer: the requester that wins when both are valid.
  logic rr;
  logic grant0;
  logic grant1;
  logic handshake;

  // Tag pipeline: one {valid, id} entry per cycle of Mask latency, plus the
  // input-register stage. The last entry lines up with a valid mask_out.
  logic [MASK_LAT:0] tag_valid;
  logic [MASK_LAT:0] tag_id;

  // Combinational arbitration; reset suppresses every grant so that no
  // handshake can complete while state is being cleared.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    grant0    = ~rst & en & req0_valid & (~rr | ~req1_valid);
    grant1    = ~rst & en & req1_valid & (rr | ~req0_valid);
    handshake = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Register the winner's operands onto the Mask and hand priority over.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr       <= 1'b0;
      mask_in  <= '0;
      position <= '0;
    end else if (grant1) begin
      rr       <= 1'b0;
      mask_in  <= req1_maskin;
      position <= req1_pos;
    end else if (grant0) begin
      rr       <= 1'b1;
      mask_in  <= req0_maskin;
      position <= req0_pos;
    end
  end

  // Shift the tag pipeline every cycle; there is no backpressure anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[MASK_LAT-1:0], handshake};
      tag_id    <= {tag_id[MASK_LAT-1:0], grant1};
    end
  end

  // Capture mask_out when the oldest tag is valid; id/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= '0;
    end else if (tag_valid[MASK_LAT]) begin
      res_valid <= 1'b1;
      res_id    <= tag_id[MASK_LAT];
      res_data  <= mask_out;
    end else begin
      res_valid <= 1'b0;
    end
  end

  assign busy = (|tag_valid) | res_valid;

endmodule

// File: tb/tb_mask_arbiter.sv
// Testbench for mask_arbiter: table-driven arbitration vectors, hand-written
// corner sequences and a randomized phase, all checked every cycle against
// a transaction-level reference model (priority bit plus a result queue).
module tb_mask_arbiter;

  localparam int LAT = 1;
  localparam int DW  = 15;
  localparam int PW  = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_maskin, req1_maskin;
  logic [PW-1:0] req0_pos, req1_pos;
  logic [DW-1:0] mask_in;
  logic [PW-1:0] position;
  logic [DW-1:0] mask_out;
  logic          res_valid, res_id;
  logic [DW-1:0] res_data;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  mask_arbiter #(.MASK_LAT(LAT), .DW(DW), .PW(PW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_maskin(req0_maskin), .req0_pos(req0_pos),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_maskin(req1_maskin), .req1_pos(req1_pos),
    .mask_in(mask_in), .position(position), .mask_out(mask_out),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .busy(busy)
  );

  // Stub Mask: clears the bit selected by the low 4 bits of position.
  function automatic logic [DW-1:0] stub_fn(input logic [DW-1:0] m, input logic [PW-1:0] p);
    return m & ~(DW'(1) << p[3:0]);
  endfunction

  // Stub datapath with LAT registered stages.
  logic [DW-1:0] stub_pipe [LAT];
  always @(posedge clk) begin
    stub_pipe[0] <= stub_fn(mask_in, position);
    for (int i = 1; i < LAT; i++) stub_pipe[i] <= stub_pipe[i-1];
  end
  assign mask_out = stub_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    bit            id;
    logic [DW-1:0] data;
    int            due;
  } res_t;
  res_t          q[$];
  bit            m_rr   = 1'b0;
  logic [DW-1:0] m_mi   = '0;
  logic [PW-1:0] m_pos  = '0;
  bit            m_rid  = 1'b0;
  logic [DW-1:0] m_rdat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare all outputs of the current cycle with the model, then advance it.
  task automatic checkOutput(output bit got0, output bit got1);
    bit            g0, g1, exp_rv, id;
    logic [DW-1:0] mi;
    logic [PW-1:0] pi;
    @(negedge clk);
    g0 = !rst && en && req0_valid && (!m_rr || !req1_valid);
    g1 = !rst && en && req1_valid && (m_rr || !req0_valid);
    got0 = req0_ready;
    got1 = req1_ready;
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    chk("mask_in", 32'(mask_in), 32'(m_mi));
    chk("position", 32'(position), 32'(m_pos));
    exp_rv = (q.size() > 0) && (q[0].due == cyc);
    if (exp_rv) begin
      m_rid  = q[0].id;
      m_rdat = q[0].data;
    end
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    chk("res_id", 32'(res_id), 32'(m_rid));
    chk("res_data", 32'(res_data), 32'(m_rdat));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    if (exp_rv) void'(q.pop_front());
    if (g0 || g1) begin
      id = g1;
      mi = g1 ? req1_maskin : req0_maskin;
      pi = g1 ? req1_pos : req0_pos;
      q.push_back('{id: id, data: stub_fn(mi, pi), due: cyc + 2 + LAT});
      m_mi  = mi;
      m_pos = pi;
      m_rr  = ~id;
    end
    if (rst) begin
      q.delete();
      m_rr   = 1'b0;
      m_mi   = '0;
      m_pos  = '0;
      m_rid  = 1'b0;
      m_rdat = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one cycle of inputs and check it; returns the sampled readys.
  task automatic applyStimulus(input bit r, input bit e, input bit v0, input bit v1,
                               input logic [DW-1:0] m0, input logic [PW-1:0] p0,
                               input logic [DW-1:0] m1, input logic [PW-1:0] p1,
                               output bit got0, output bit got1);
    rst = r; en = e; req0_valid = v0; req1_valid = v1;
    req0_maskin = m0; req0_pos = p0; req1_maskin = m1; req1_pos = p1;
    checkOutput(got0, got1);
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, '0, '0, '0, '0, a, b);
  endtask

  task automatic do_reset(input int n);
    bit a, b;
    for (int i = 0; i < n; i++)
      applyStimulus(1, 1, 1, 1, 15'h7fff, 7'h7f, 15'h7fff, 7'h7f, a, b);
  endtask

  typedef struct {
    bit e, v0, v1;
    bit r0, r1;
  } vec_t;
  vec_t tab[10];

  initial begin
    bit a, b;
    logic [DW-1:0] sm;
    logic [PW-1:0] sp;
    bit exp_g;

    rst = 1; en = 1; req0_valid = 1; req1_valid = 1;
    req0_maskin = '0; req0_pos = '0; req1_maskin = '0; req1_pos = '0;
    @(posedge clk);
    #1;

    // Reset with both valids high: no readys, all outputs zero.
    do_reset(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mask_in", 32'(mask_in), 32'd0);

    // Arbitration table from a fresh reset (priority starts at requester 0).
    tab[0] = '{1, 1, 1, 1, 0};
    tab[1] = '{1, 1, 1, 0, 1};
    tab[2] = '{1, 0, 1, 0, 1};
    tab[3] = '{1, 1, 1, 1, 0};
    tab[4] = '{0, 1, 1, 0, 0};
    tab[5] = '{1, 1, 0, 1, 0};
    tab[6] = '{1, 1, 1, 0, 1};
    tab[7] = '{1, 0, 0, 0, 0};
    tab[8] = '{1, 1, 1, 1, 0};
    tab[9] = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, tab[i].e, tab[i].v0, tab[i].v1,
                    DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
      chk("tab_ready0", 32'(a), 32'(tab[i].r0));
      chk("tab_ready1", 32'(b), 32'(tab[i].r1));
    end
    idle(5);

    // Single issue from requester 0 and its exact result timing.
    sm = 15'b111101111011110;
    sp = 7'b0011000;
    applyStimulus(0, 1, 1, 0, sm, sp, '0, '0, a, b);
    chk("si_mask_in", 32'(mask_in), 32'(sm));
    chk("si_position", 32'(position), 32'(sp));
    idle(1);
    chk("si_res_valid_early", 32'(res_valid), 32'd0);
    idle(1);
    chk("si_res_valid", 32'(res_valid), 32'd1);
    chk("si_res_id", 32'(res_id), 32'd0);
    chk("si_res_data", 32'(res_data), 32'(stub_fn(sm, sp)));
    idle(1);
    chk("si_res_valid_end", 32'(res_valid), 32'd0);
    idle(2);

    // Contention after reset: strict alternation 0,1,0,1,0,1.
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
      chk("cont_grant0", 32'(a), 32'((i % 2) == 0));
      chk("cont_grant1", 32'(b), 32'((i % 2) == 1));
    end
    idle(5);
    chk("cont_busy_done", 32'(busy), 32'd0);

    // Lone requester 1 wins against the priority holder, then priority returns.
    do_reset(1);
    applyStimulus(0, 1, 0, 1, '0, '0, 15'b100101001011110, 7'b0111000, a, b);
    chk("lone_ready1", 32'(b), 32'd1);
    applyStimulus(0, 1, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    chk("lone_rr_back0", 32'(a), 32'd1);
    idle(5);

    // Enable gating: nothing issues while en=0, the pipe drains, grants resume.
    applyStimulus(0, 1, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    exp_g = m_rr;
    for (int i = 0; i < 5; i++)
      applyStimulus(0, 0, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    chk("en_busy_drained", 32'(busy), 32'd0);
    applyStimulus(0, 1, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    chk("en_resume", 32'(b), 32'(exp_g));
    idle(5);

    // Reset in flight: two issued operations never produce results.
    applyStimulus(0, 1, 1, 0, DW'($urandom), PW'($urandom), '0, '0, a, b);
    applyStimulus(0, 1, 0, 1, '0, '0, DW'($urandom), PW'($urandom), a, b);
    applyStimulus(1, 1, 1, 1, DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    chk("rif_mask_in", 32'(mask_in), 32'd0);
    chk("rif_busy", 32'(busy), 32'd0);
    idle(5);

    // Randomized traffic, including occasional en drops and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
                    1'($urandom), 1'($urandom),
                    DW'($urandom), PW'($urandom), DW'($urandom), PW'($urandom), a, b);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mask_arbiter.md
# mask_arbiter

Round-robin arbiter and sequencer that shares one Mask datapath instance (15-bit mask input, 7-bit position, 15-bit masked output) between two requesters in the Gaussian noise generator. It accepts requests through valid/ready handshakes and registers the winning operands onto the Mask inputs. It tracks each operation through the Mask's fixed latency and returns every result, tagged with its requester ID, on a single result port.

## Interface
- MASK_LAT, 1: cycles from Mask inputs stable to Mask output valid; legal range 1..4.
- DW, 15: mask data width.
- PW, 7: position width.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  issue enable; 0 blocks new grants, in-flight operations still complete.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 granted this cycle (combinational).
- req0_maskin  in  DW  requester 0 mask operand.
- req0_pos  in  PW  requester 0 position operand.
- req1_valid, req1_ready, req1_maskin, req1_pos: same as requester 0.
- mask_in  out  DW  drives Mask Maskin; registered.
- position  out  PW  drives Mask position; registered.
- mask_out  in  DW  from Mask Maskout.
- res_valid  out  1  one-cycle pulse per completed operation.
- res_id  out  1  requester of the current result.
- res_data  out  DW  masked result.
- busy  out  1  any operation in flight or result pending.

## Operation
- Arbitration is combinational. grant0 = en & req0_valid & (rr==0 | ~req1_valid); grant1 = en & req1_valid & (rr==1 | ~req0_valid). reqN_ready = grantN. At most one grant per cycle.
- A handshake is reqN_valid & reqN_ready. On a handshake, mask_in/position <= the winner's operands, and rr <= the other requester.
- With no handshake, mask_in/position and rr hold their values.
- Tag pipeline: MASK_LAT+1 stages of {valid, id}. Stage 0 loads {handshake, winner id}; each stage shifts every cycle, unconditionally.
- When the final stage is valid: res_valid <= 1, res_id <= tag id, res_data <= mask_out. Otherwise res_valid <= 0, and res_id/res_data hold.
- The result port has no backpressure; throughput is one operation per cycle.
- busy = OR of all tag-stage valid bits | res_valid.
- Reset: rr=0, mask_in=0, position=0, all tag valids=0, res_valid=0, res_id=0, res_data=0, busy=0.
- Ready stays 0 during any cycle in which rst=1.
- Reset mid-operation: all in-flight tags are discarded, and no res_valid is produced for them.
- en deasserted mid-stream: the pipeline drains normally and busy falls once the last result has been emitted.

## Timing
- Handshake in cycle T. mask_in/position are visible at T+1.
- mask_out is valid at T+1+MASK_LAT and is sampled at that edge.
- res_valid/res_id/res_data are visible at T+2+MASK_LAT. With MASK_LAT=1 this is T+3.
- Back-to-back handshakes at T and T+1 produce results at consecutive cycles, in issue order.
- Simultaneous valid: the rr holder wins. A lone valid wins regardless of rr.
- A requester holding valid loses at most one cycle to the other requester.
- The first cycle after rst falls may already grant.

## Test plan
- Reset: hold rst 2 cycles with both valids high. Required: both readys=0; mask_in, position, res_valid, res_id, res_data and busy all 0.
- Single issue, MASK_LAT=1, 4-bit stub Mask registering mask_out. Drive req0 with maskin=15'b111101111011110, pos=7'b0011000 at T. Required: mask_in/position equal those values at T+1; res_valid=1 at T+3 with res_id=0 and res_data = the stub output sampled at T+2; res_valid=0 at T+4.
- Contention: both valids held high for 6 cycles after reset. Required: grant sequence 0,1,0,1,0,1; res_id sequence 0,1,0,1,0,1 on 6 consecutive res_valid cycles; busy drops 1 cycle after the last result.
- Lone requester: rr=0, only req1_valid with maskin=15'b100101001011110, pos=7'b0111000. Required: req1_ready=1 the same cycle; rr becomes 0 afterwards; result tagged res_id=1.
- en gating: both valid, en=0 for 5 cycles. Required: no ready, no new tags; pipeline drains and busy reaches 0; grants resume the cycle en returns to 1.
- Reset in flight: issue 2 operations, assert rst at T+1 for 1 cycle. Required: res_valid never pulses for either operation; all outputs equal reset values from T+2.
